mips_fetch_unit: RTL and testbench

Instruction-fetch front end for the 5-stage MIPS pipeline. It drives `IF_instr` into the IF/ID register, honours the hazard unit's `Stall`, and accepts branch/jump redirects. It fetches from a variable-latency instruction memory over a request/grant/response handshake and buffers returned words in a small in-order prefetch FIFO. When no instruction is ready it inserts NOP bubbles.

---
 rtl/mips_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/mips_fetch_unit.sv | 116 +++++++++++
 tb/tb_mips_fetch_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch front end: instruction word, bubble word
// and the {instr, pc} entry held in the prefetch buffer.
package mips_pkg;
  typedef logic [31:0] word_t;

  localparam word_t MIPS_NOP = 32'h0000_0000;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is combinational from storage.
// Depth need not be a power of two, so pointers wrap explicitly.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i)  rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: credit-limited requests to a variable-latency
// imem, in-order prefetch buffer, registered IF output with NOP bubbles.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter int    BUF_DEPTH = 2,
  parameter word_t NOP       = MIPS_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_instr,
  output logic [31:0] IF_pc,
  output logic        IF_valid
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int DW = $clog2(2 * BUF_DEPTH + 1) + 1;

  word_t         pc_q, pc_d;
  logic [CW-1:0] o_q, o_d, f_cnt, a_cnt;
  logic [DW-1:0] d_q, d_d;
  logic          fire, live, f_push, f_pop;
  word_t         a_head;
  fetch_entry_t  f_head, f_din;
  word_t         instr_q, opc_q;
  logic          vld_q;

  // Credits cover both in-flight and buffered words, so the buffer never overflows.
  assign imem_req  = !reset && ((int'(o_q) + int'(f_cnt)) < BUF_DEPTH);
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_gnt;
  assign live      = imem_rvalid && (d_q == '0);

  assign f_din  = '{instr: imem_rdata, pc: a_head};
  assign f_push = live && (stall || f_cnt != '0);
  assign f_pop  = !stall && (f_cnt != '0);

  fetch_fifo #(.DEPTH(BUF_DEPTH), .W($bits(fetch_entry_t))) u_data_fifo (
    .clk(clk), .reset(reset), .push_i(f_push), .pop_i(f_pop), .flush_i(redirect),
    .din_i(f_din), .head_o(f_head), .count_o(f_cnt)
  );

  // Holds addresses of live requests only; dropped ones vanish on redirect.
  fetch_fifo #(.DEPTH(BUF_DEPTH), .W(32)) u_addr_fifo (
    .clk(clk), .reset(reset), .push_i(fire), .pop_i(live), .flush_i(redirect),
    .din_i(pc_q), .head_o(a_head), .count_o(a_cnt)
  );

  always_comb begin
    pc_d = pc_q;
    o_d  = o_q + CW'(fire) - CW'(live);
    d_d  = d_q - DW'(imem_rvalid && !live);
    if (redirect) begin
      pc_d = redirect_pc & ~32'd3;
      o_d  = '0;
      // Every request still in flight, including one granted now, becomes a drop.
      d_d  = d_q + DW'(o_q) + DW'(fire) - DW'(imem_rvalid);
    end else if (fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      o_q  <= '0;
      d_q  <= '0;
    end else begin
      pc_q <= pc_d;
      o_q  <= o_d;
      d_q  <= d_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP;
      opc_q   <= RESET_PC;
      vld_q   <= 1'b0;
    end else if (redirect) begin
      instr_q <= NOP;
      vld_q   <= 1'b0;
    end else if (!stall) begin
      if (f_cnt != '0) begin
        instr_q <= f_head.instr;
        opc_q   <= f_head.pc;
        vld_q   <= 1'b1;
      end else if (live) begin
        instr_q <= imem_rdata;
        opc_q   <= a_head;
        vld_q   <= 1'b1;
      end else begin
        instr_q <= NOP;
        vld_q   <= 1'b0;
      end
    end
  end

  assign IF_instr = instr_q;
  assign IF_pc    = opc_q;
  assign IF_valid = vld_q;

  a_credit: assert property (@(posedge clk) disable iff (reset)
    (int'(f_cnt) <= BUF_DEPTH) && ((int'(o_q) + int'(f_cnt)) <= BUF_DEPTH));
  a_addr_sync: assert property (@(posedge clk) disable iff (reset) a_cnt == o_q);
  a_proto: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && o_q == '0 && d_q == '0));
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: in-order fixed-latency imem model
// returning addr ^ A5A5_0000, hand-timed expected IF outputs.
module tb_mips_fetch_unit;
  localparam logic [31:0] NOP_W = 32'h0000_0000;
  localparam logic [31:0] XORK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_instr, IF_pc;
  logic        IF_valid;

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 1;
  int cyc   = 0;
  logic [31:0] qa[$];
  int          qd[$];

  mips_fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2), .NOP(NOP_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_instr(IF_instr), .IF_pc(IF_pc), .IF_valid(IF_valid)
  );

  always #5 clk = ~clk;

  // Record accepted requests mid-cycle, when req/gnt are settled.
  always @(negedge clk) begin
    if (reset) begin
      qa.delete();
      qd.delete();
    end else if (imem_req && imem_gnt) begin
      qa.push_back(imem_addr);
      qd.push_back(cyc + lat);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic exp_out(input string tag, input logic [31:0] pc, input logic v);
    chk({tag, ".pc"}, IF_pc, pc);
    chk({tag, ".vld"}, {31'b0, IF_valid}, {31'b0, v});
    chk({tag, ".ins"}, IF_instr, v ? (pc ^ XORK) : NOP_W);
  endtask

  // Advance one clock; drive the memory response for the new cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (!reset && qd.size() > 0 && qd[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = qa[0] ^ XORK;
      void'(qa.pop_front());
      void'(qd.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  logic [31:0] t3_pc [12] = '{0, 0, 0, 0, 0, 4, 4, 4, 4, 8, 12, 12};
  bit          t3_v  [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    cycle();
    cycle();
    chk("rst.req", {31'b0, imem_req}, 32'd0);
    chk("rst.addr", imem_addr, 32'h0);
    exp_out("rst", 32'h0, 1'b0);

    // 1-cycle memory streaming, then a 3-cycle stall at pc 8
    reset = 1'b0;
    cycle(); exp_out("s.first", 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin cycle(); exp_out("s.run", 32'(4 * i), 1'b1); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(); exp_out("st.hold", 32'h8, 1'b1);
      if (i < 2) chk("st.req", {31'b0, imem_req}, 32'd0);
      if (i == 1) stall = 1'b1;
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin cycle(); exp_out("st.resume", 32'(12 + 4 * i), 1'b1); end

    // 4-cycle memory: two outstanding, bubbles between pairs
    lat = 4;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(); exp_out("l4", t3_pc[i], t3_v[i]);
      if (i == 1 || i == 2) chk("l4.req", {31'b0, imem_req}, 32'd0);
    end

    // redirect with two requests in flight on the slow memory
    do_reset();
    cycle(); cycle();
    chk("rd.full", {31'b0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cycle(); redirect = 1'b0;
    chk("rd.addr", imem_addr, 32'h100);
    chk("rd.req", {31'b0, imem_req}, 32'd1);
    exp_out("rd.bub", 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin cycle(); exp_out("rd.drop", 32'h0, 1'b0); end
    cycle(); exp_out("rd.tgt0", 32'h100, 1'b1);
    cycle(); exp_out("rd.tgt1", 32'h104, 1'b1);

    // redirect coinciding with a grant and a stall, 1-cycle memory
    lat = 1;
    do_reset();
    cycle(); cycle(); cycle();
    exp_out("rs.pre", 32'h4, 1'b1);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    cycle(); stall = 1'b0; redirect = 1'b0;
    exp_out("rs.bub", 32'h4, 1'b0);
    chk("rs.addr", imem_addr, 32'h200);
    chk("rs.req", {31'b0, imem_req}, 32'd1);
    cycle(); exp_out("rs.bub2", 32'h4, 1'b0);
    cycle(); exp_out("rs.tgt0", 32'h200, 1'b1);
    cycle(); exp_out("rs.tgt1", 32'h204, 1'b1);

    // pc wrap at the top of the address space, then mid-stream reset
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle(); redirect = 1'b0;
    exp_out("wr.bub", 32'h204, 1'b0);
    cycle();
    chk("wr.addr", imem_addr, 32'h0);
    cycle(); exp_out("wr.top", 32'hFFFF_FFFC, 1'b1);
    cycle(); exp_out("wr.zero", 32'h0, 1'b1);
    reset = 1'b1;
    cycle();
    exp_out("mr.rst", 32'h0, 1'b0);
    chk("mr.req", {31'b0, imem_req}, 32'd0);
    reset = 1'b0;
    cycle(); exp_out("mr.b", 32'h0, 1'b0);
    cycle(); exp_out("mr.s0", 32'h0, 1'b1);
    cycle(); exp_out("mr.s1", 32'h4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
